// File: rtl/uart_word_rx_pkg.sv
// Shared definitions for the UART word receiver.
//   rx_state_e : receive FSM state encoding
//   DATA_BITS  : data bits per frame (8N1 framing)
//   STOP_BITS  : stop bits per frame
//   clog2()    : ceiling log2 for counter widths (minimum result 1)
package uart_word_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, frame FSM, byte strobe and
// frame error strobe.
// Ports:
//   clk, rst         : clock, async active-high reset
//   rx               : asynchronous serial input, idle high
//   byte_out         : last accepted byte (held)
//   byte_valid       : one-cycle pulse when byte_out updates
//   frame_err        : one-cycle pulse when the stop bit is sampled low
//   in_idle          : FSM is in IDLE
//   start_det        : start edge seen this cycle (IDLE and line low)
//   accept           : this cycle's stop sample accepts the byte
//   reject           : this cycle's stop sample is a framing error
//   accept_data      : byte being accepted (valid with accept)
//
// state      | meaning
// IDLE       | line idle, waiting for a low level
// START      | timing to the middle of the start bit
// DATA       | sampling 8 data bits LSB first, one per bit time
// STOP       | timing to the middle of the stop bit
// WAIT_IDLE  | framing error seen, waiting for the line to return high
module uart_byte_rx
    import uart_word_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       in_idle,
    output logic       start_det,
    output logic       accept,
    output logic       reject,
    output logic [7:0] accept_data
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic [1:0]       sync_q;
    logic             rx_s;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_out_q, byte_out_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_out_d   = shift_q;
                        byte_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Synchroniser presets high so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= 2'b11;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_out    = byte_out_q;
    assign byte_valid  = byte_valid_q;
    assign frame_err   = frame_err_q;
    assign in_idle     = (state_q == ST_IDLE);
    assign start_det   = (state_q == ST_IDLE) && !rx_s;
    assign accept      = (state_q == ST_STOP) && (cnt_q == FULL_M1) && rx_s;
    assign reject      = (state_q == ST_STOP) && (cnt_q == FULL_M1) && !rx_s;
    assign accept_data = shift_q;

endmodule

// File: rtl/uart_word_rx.sv
// UART word receiver: assembles four consecutive bytes little-endian into a
// 32-bit word and discards a partial word after an idle timeout.
// Ports:
//   clk, rst    : clock, async active-high reset
//   rx          : asynchronous serial input, idle high
//   byte_out    : last received byte; byte_valid pulses when it updates
//   word_out    : last assembled word (first byte in [7:0]); word_valid pulses
//   frame_err   : pulse, stop bit sampled low (partial word dropped)
//   timeout     : pulse, partial word dropped after idle timeout
//   byte_idx    : bytes held toward the next word (0..3)
module uart_word_rx
    import uart_word_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        frame_err,
    output logic        timeout,
    output logic [1:0]  byte_idx
);

    localparam int IDLE_W = clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT_M1 = IDLE_W'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

    logic        in_idle;
    logic        start_det;
    logic        accept;
    logic        reject;
    logic [7:0]  accept_data;

    logic [23:0]       hold_q, hold_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_out_q, word_out_d;
    logic              word_valid_q, word_valid_d;
    logic              timeout_q, timeout_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .in_idle    (in_idle),
        .start_det  (start_det),
        .accept     (accept),
        .reject     (reject),
        .accept_data(accept_data)
    );

    // Acting on the pre-register accept strobe keeps word_valid and byte_idx
    // aligned with the sub-module's registered byte_valid.
    always_comb begin
        hold_d       = hold_q;
        byte_idx_d   = byte_idx_q;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        timeout_d    = 1'b0;
        idle_cnt_d   = idle_cnt_q;

        if (accept) begin
            case (byte_idx_q)
                2'd0:    hold_d[7:0]   = accept_data;
                2'd1:    hold_d[15:8]  = accept_data;
                2'd2:    hold_d[23:16] = accept_data;
                default: begin
                    word_out_d   = {accept_data, hold_q};
                    word_valid_d = 1'b1;
                end
            endcase
            byte_idx_d = byte_idx_q + 2'd1;
        end else if (reject) begin
            byte_idx_d = 2'd0;
        end

        // accept/reject only occur outside IDLE, so they never meet a timeout.
        if (!in_idle || start_det || (byte_idx_q == 2'd0)) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LIMIT_M1) begin
            idle_cnt_d = '0;
            timeout_d  = 1'b1;
            byte_idx_d = 2'd0;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q       <= '0;
            byte_idx_q   <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            idle_cnt_q   <= '0;
        end else begin
            hold_q       <= hold_d;
            byte_idx_q   <= byte_idx_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            timeout_q    <= timeout_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign timeout    = timeout_q;
    assign byte_idx   = byte_idx_q;

endmodule
